axis_adain_feeder: RTL and testbench
====================================

# axis_adain_feeder

AXI-Stream transmitter that drives the slave port of `axis_adain` with the exact two-pass frame that block consumes. Per channel it emits:
- the `ys` and `yb` metadata beats;
- a SCAN pass of N×N Q32.16 pixels, forwarded from an upstream DMA stream and captured into an internal buffer;
- a NORMALISATION pass replayed from that buffer.

It sits between the DMA MM2S stream and `axis_adain`, so software streams each channel only once.

## Interface
Parameters:
- `WIDTH_IN`, 48: pixel/metadata width, Q32.16.
- `N_MAX`, 128: maximum channel side length.
- `ADDR_W`, 14: buffer address width, equal to clog2(N_MAX·N_MAX).

Ports:
- `clk`  in  1  single clock domain.
- `rstn`  in  1  reset; asynchronous, active-low.
- `gpio_N_sel`  in  3  side-length select, latched at `start`.
- `start`  in  1  one-cycle pulse; begins one channel.
- `ys`  in  WIDTH_IN  style scale, latched at `start`.
- `yb`  in  WIDTH_IN  style bias, latched at `start`.
- `busy`  out  1  high from `start` acceptance until the final replay beat.
- `done`  out  1  one-cycle pulse after the final replay handshake.
- `err_tlast`  out  1  sticky upstream framing error; cleared only by the next accepted `start`.
- `s_axis_tdata`  in  WIDTH_IN  upstream pixel.
- `s_axis_tvalid`  in  1  upstream valid.
- `s_axis_tready`  out  1  upstream ready.
- `s_axis_tlast`  in  1  upstream last; checked but never forwarded.
- `m_axis_tdata`  out  WIDTH_IN  beat to `axis_adain`.
- `m_axis_tvalid`  out  1  downstream valid.
- `m_axis_tready`  in  1  downstream ready.
- `m_axis_tlast`  out  1  downstream last.

## Operation
- N = 4 << `gpio_N_sel` for sel 0–5. Sel 6 and 7 clamp to N_MAX. P = N·N.
- State machine: IDLE → SEND_YS → SEND_YB → SCAN → REPLAY → IDLE.
- **IDLE:** `s_axis_tready` = 0 and `m_axis_tvalid` = 0. A `start` pulse latches N, `ys` and `yb`, clears `err_tlast` and the counters, and moves to SEND_YS. `start` is ignored in every other state.
- **SEND_YS:** `m_axis_tvalid` = 1, tdata = latched `ys`, tlast = 0. On handshake, go to SEND_YB.
- **SEND_YB:** same as SEND_YS with latched `yb`. On handshake, go to SCAN.
- **SCAN:** zero-latency combinational pass-through.
  - `m_axis_tvalid` = `s_axis_tvalid`, `s_axis_tready` = `m_axis_tready`, `m_axis_tdata` = `s_axis_tdata`.
  - Each handshake writes the pixel to buffer[idx] and increments idx.
  - `m_axis_tlast` = (idx == P−1), generated internally.
  - If upstream tlast ≠ (idx == P−1) on any handshake, set `err_tlast`. The count stays authoritative.
  - After beat P−1, reset idx and go to REPLAY.
- **REPLAY:** `s_axis_tready` = 0.
  - Reads buffer[0..P−1] in order into a 2-entry output skid.
  - `m_axis_tlast` is asserted on beat P−1.
  - After the P−1 handshake: pulse `done`, drop `busy`, return to IDLE.
- Downstream stalls, including `axis_adain` holding tready low while it computes statistics, are absorbed by holding data stable. No beat is dropped or duplicated.
- Buffer contents are undefined after reset. Nothing is read before it is written in the same channel.

## Timing
- Reset values: all outputs 0, state IDLE.
- Reset asserted mid-operation: outputs clear asynchronously and any in-flight beat is abandoned.
- `start` at edge t: `busy` and `m_axis_tvalid` (carrying `ys`) are high after edge t.
- SCAN adds 0 cycles of latency and its throughput equals the upstream/downstream handshake rate.
- Buffer: synchronous read, 1-cycle latency.
- REPLAY with `m_axis_tready` held high:
  - first `m_axis_tvalid` no later than 2 cycles after entering REPLAY;
  - then one beat per cycle sustained;
  - at most 2 reads outstanding.
- AXIS rules: tvalid never depends on tready, and tdata/tlast are held while tvalid·!tready.
- `done` is a single-cycle pulse.

## Structure
- Shared package `adain_pkg`:
  - WIDTH_IN;
  - N_MAX;
  - ADDR_W;
  - the N_sel-to-N decode function;
  - the state enum.
- Sub-module `adain_line_buffer`: simple dual-port RAM of N_MAX² × WIDTH_IN, synchronous write and synchronous read, inferable as BRAM.
- The top level holds the FSM, counters, pass-through mux and replay skid.

## Test plan
- **Basic frame:** N_sel=0, `ys`=0x000000010000, `yb`=0. Upstream pixels (i+1)<<16 for i=0..15, tlast on the 16th, both ready/valid always high. Required: 34 downstream beats in order `ys`, `yb`, 16 pixels (tlast on beat 18), then the same 16 pixels (tlast on beat 34). One `done` pulse, `err_tlast`=0.
- **Throttled handshakes:** same data, with upstream tvalid toggling every cycle and `m_axis_tready` toggling every 2 cycles. Required: identical 34-beat sequence, no duplicates, no drops.
- **Framing error:** upstream tlast asserted early on pixel 10. Required: `err_tlast`=1 from that handshake, downstream tlast still only on pixel 16, and replay correct.
- **Maximum size:** N_sel=5, 16384 pixels with value = index, `m_axis_tready` held high during replay. Required: first replay beat within 2 cycles of entering REPLAY, then 16384 back-to-back beats, last beat = 16383 with tlast.
- **Reset mid-replay:** assert `rstn` low during REPLAY. Required: all outputs 0 immediately. A following `start` with N_sel=7 runs a full N=128 frame.
- **Start while busy:** pulse `start` during SCAN. Required: ignored; the current frame completes unaltered and only one `done` pulse is produced.

Source files
------------

// File: rtl/adain_pkg.sv
// Shared types and constants for the axis_adain feeder.
// Holds widths, the N_sel decode and the FSM state enum.
package adain_pkg;

  localparam int WIDTH_IN = 48;
  localparam int N_MAX    = 128;
  localparam int ADDR_W   = 14;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_YS,
    ST_YB,
    ST_SCAN,
    ST_REPLAY
  } state_t;

  function automatic logic [7:0] n_decode(
    input logic [2:0] sel
  );
    return (sel > 3'd5) ? 8'(N_MAX)
                        : (8'd4 << sel);
  endfunction

  // Index of the last pixel, P-1 = N*N-1.
  function automatic logic [ADDR_W-1:0] last_idx(
    input logic [2:0] sel
  );
    logic [ADDR_W:0] n;
    logic [ADDR_W:0] p;
    n = (ADDR_W+1)'(n_decode(sel));
    p = n * n - (ADDR_W+1)'(1);
    return p[ADDR_W-1:0];
  endfunction

endpackage

// File: rtl/adain_line_buffer.sv
// Simple dual-port channel buffer, sync write / sync read.
// Ports: we/waddr/wdata write side, re/raddr/rdata read side.
module adain_line_buffer #(
  parameter int W     = 48,
  parameter int AW    = 14,
  parameter int DEPTH = 16384
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [W-1:0]  wdata,
  input  logic          re,
  input  logic [AW-1:0] raddr,
  output logic [W-1:0]  rdata
);

  logic [W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    if (re) rdata <= mem[raddr];
  end

endmodule

// File: rtl/axis_adain_feeder.sv
// Emits ys, yb, a pass-through SCAN and a buffered REPLAY per channel.
// Ports: start/ys/yb/gpio_N_sel control, s_axis in, m_axis out.
module axis_adain_feeder
  import adain_pkg::*;
#(
  parameter int WIDTH_IN = adain_pkg::WIDTH_IN,
  parameter int N_MAX    = adain_pkg::N_MAX,
  parameter int ADDR_W   = adain_pkg::ADDR_W
) (
  input  logic                clk,
  input  logic                rstn,
  input  logic [2:0]          gpio_N_sel,
  input  logic                start,
  input  logic [WIDTH_IN-1:0] ys,
  input  logic [WIDTH_IN-1:0] yb,
  output logic                busy,
  output logic                done,
  output logic                err_tlast,
  input  logic [WIDTH_IN-1:0] s_axis_tdata,
  input  logic                s_axis_tvalid,
  output logic                s_axis_tready,
  input  logic                s_axis_tlast,
  output logic [WIDTH_IN-1:0] m_axis_tdata,
  output logic                m_axis_tvalid,
  input  logic                m_axis_tready,
  output logic                m_axis_tlast
);

  state_t state, state_nx;

  logic [WIDTH_IN-1:0] ys_q, yb_q;
  logic [WIDTH_IN-1:0] rdata;
  logic [WIDTH_IN-1:0] sk_data [2];
  logic [ADDR_W-1:0]   plast, idx, ocnt;
  logic [1:0]          sk_cnt;
  logic [2:0]          occ;
  logic                sk_rp, sk_wp;
  logic                issued_all, rd_pend;
  logic                scan_hs, pop, push, issue;

  assign busy    = (state != ST_IDLE);
  assign scan_hs = (state == ST_SCAN) && s_axis_tvalid
                   && m_axis_tready;
  assign pop     = (state == ST_REPLAY) && (sk_cnt != 2'd0)
                   && m_axis_tready;
  assign push    = rd_pend;

  // Skid occupancy once this cycle's push/pop settle;
  // a new read is only issued if its data has a slot.
  assign occ   = 3'(sk_cnt) + 3'(rd_pend) - 3'(pop);
  assign issue = (state == ST_REPLAY) && !issued_all
                 && (occ < 3'd2);

  adain_line_buffer #(
    .W     (WIDTH_IN),
    .AW    (ADDR_W),
    .DEPTH (N_MAX * N_MAX)
  ) u_buf (
    .clk   (clk),
    .we    (scan_hs),
    .waddr (idx),
    .wdata (s_axis_tdata),
    .re    (issue),
    .raddr (idx),
    .rdata (rdata)
  );

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) state <= ST_IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx      = state;
    s_axis_tready = 1'b0;
    m_axis_tvalid = 1'b0;
    m_axis_tdata  = '0;
    m_axis_tlast  = 1'b0;
    unique case (state)
      ST_IDLE: begin
        if (start) state_nx = ST_YS;
      end
      ST_YS: begin
        m_axis_tvalid = 1'b1;
        m_axis_tdata  = ys_q;
        if (m_axis_tready) state_nx = ST_YB;
      end
      ST_YB: begin
        m_axis_tvalid = 1'b1;
        m_axis_tdata  = yb_q;
        if (m_axis_tready) state_nx = ST_SCAN;
      end
      ST_SCAN: begin
        m_axis_tvalid = s_axis_tvalid;
        s_axis_tready = m_axis_tready;
        m_axis_tdata  = s_axis_tdata;
        m_axis_tlast  = (idx == plast);
        if (scan_hs && idx == plast)
          state_nx = ST_REPLAY;
      end
      ST_REPLAY: begin
        m_axis_tvalid = (sk_cnt != 2'd0);
        m_axis_tdata  = sk_data[sk_rp];
        m_axis_tlast  = (ocnt == plast);
        if (pop && ocnt == plast)
          state_nx = ST_IDLE;
      end
      default: state_nx = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      ys_q       <= '0;
      yb_q       <= '0;
      plast      <= '0;
      idx        <= '0;
      ocnt       <= '0;
      err_tlast  <= 1'b0;
      done       <= 1'b0;
      issued_all <= 1'b0;
      rd_pend    <= 1'b0;
      sk_cnt     <= '0;
      sk_rp      <= 1'b0;
      sk_wp      <= 1'b0;
      sk_data[0] <= '0;
      sk_data[1] <= '0;
    end else begin
      done    <= 1'b0;
      rd_pend <= issue;
      if (state == ST_IDLE && start) begin
        ys_q       <= ys;
        yb_q       <= yb;
        plast      <= last_idx(gpio_N_sel);
        err_tlast  <= 1'b0;
        idx        <= '0;
        ocnt       <= '0;
        issued_all <= 1'b0;
        sk_cnt     <= '0;
        sk_rp      <= 1'b0;
        sk_wp      <= 1'b0;
      end
      // Upstream tlast is only checked; the count wins.
      if (scan_hs) begin
        if (s_axis_tlast != (idx == plast))
          err_tlast <= 1'b1;
        idx <= (idx == plast) ? '0
                              : idx + ADDR_W'(1);
      end
      if (issue) begin
        idx <= idx + ADDR_W'(1);
        if (idx == plast) issued_all <= 1'b1;
      end
      if (push) begin
        sk_data[sk_wp] <= rdata;
        sk_wp          <= ~sk_wp;
      end
      if (pop) begin
        sk_rp <= ~sk_rp;
        ocnt  <= ocnt + ADDR_W'(1);
        if (ocnt == plast) done <= 1'b1;
      end
      if (push != pop)
        sk_cnt <= push ? sk_cnt + 2'd1
                       : sk_cnt - 2'd1;
    end
  end

endmodule

// File: tb/tb_axis_adain_feeder.sv
// Directed self-checking bench for axis_adain_feeder.
// Monitors downstream beats and compares to hand-built frames.
module tb_axis_adain_feeder;

  logic        clk;
  logic        rstn;
  logic [2:0]  gpio_N_sel;
  logic        start;
  logic [47:0] ys, yb;
  logic        busy, done, err_tlast;
  logic [47:0] s_axis_tdata;
  logic        s_axis_tvalid, s_axis_tready, s_axis_tlast;
  logic [47:0] m_axis_tdata;
  logic        m_axis_tvalid, m_axis_tready, m_axis_tlast;

  typedef struct {
    logic [47:0] d;
    logic        l;
    logic        e;
    int          c;
  } beat_t;

  beat_t q[$];
  int    ncyc = 0;
  int    done_cnt = 0;
  int    checks = 0;
  int    fails = 0;

  localparam logic [47:0] YS1 = 48'h0000_0001_0000;

  axis_adain_feeder dut (
    .clk           (clk),
    .rstn          (rstn),
    .gpio_N_sel    (gpio_N_sel),
    .start         (start),
    .ys            (ys),
    .yb            (yb),
    .busy          (busy),
    .done          (done),
    .err_tlast     (err_tlast),
    .s_axis_tdata  (s_axis_tdata),
    .s_axis_tvalid (s_axis_tvalid),
    .s_axis_tready (s_axis_tready),
    .s_axis_tlast  (s_axis_tlast),
    .m_axis_tdata  (m_axis_tdata),
    .m_axis_tvalid (m_axis_tvalid),
    .m_axis_tready (m_axis_tready),
    .m_axis_tlast  (m_axis_tlast)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Inputs change at posedge+1, so negedge sees the
  // values the next posedge will handshake on.
  always @(negedge clk) begin
    ncyc++;
    if (rstn && m_axis_tvalid && m_axis_tready)
      q.push_back('{d: m_axis_tdata, l: m_axis_tlast,
                    e: err_tlast, c: ncyc});
    if (done) done_cnt++;
  end

  task automatic chk(input string tag,
                     input logic [63:0] obs,
                     input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h",
             tag, obs, exp);
    end
  endtask

  function automatic logic [47:0] pix(input int k,
                                      input bit vm);
    return vm ? 48'(k) : (48'(k + 1) << 16);
  endfunction

  task automatic do_start(input logic [2:0] sel,
                          input logic [47:0] vys,
                          input logic [47:0] vyb);
    gpio_N_sel = sel;
    ys         = vys;
    yb         = vyb;
    start      = 1'b1;
    @(posedge clk); #1;
    start      = 1'b0;
  endtask

  task automatic drive(input int np, input int early,
                       input bit thr, input bit vm,
                       input bit poke, input int abort,
                       input int budget);
    int k = 0;
    int cyc = 0;
    bit poked = 1'b0;
    while (busy && cyc < budget
           && !(abort > 0 && q.size() >= abort)) begin
      s_axis_tvalid = (k < np) && (!thr || cyc % 2 == 1);
      s_axis_tdata  = pix(k, vm);
      s_axis_tlast  = (early >= 0) ? (k == early)
                                   : (k == np - 1);
      m_axis_tready = !thr || ((cyc / 2) % 2 == 1);
      start = 1'b0;
      if (poke && !poked && k == 5 && s_axis_tvalid) begin
        start      = 1'b1;
        gpio_N_sel = 3'd7;
        ys         = 48'hFFFF_FFFF_FFFF;
        poked      = 1'b1;
      end
      @(negedge clk);
      if (s_axis_tvalid && s_axis_tready) k++;
      @(posedge clk); #1;
      cyc++;
    end
    start         = 1'b0;
    s_axis_tvalid = 1'b0;
    s_axis_tlast  = 1'b0;
    m_axis_tready = 1'b1;
    chk($sformatf("budget_np%0d", np),
        64'(cyc < budget), 64'd1);
  endtask

  task automatic settle();
    repeat (3) @(posedge clk);
    #1;
  endtask

  task automatic check_frame(input string tag,
                             input logic [47:0] eys,
                             input logic [47:0] eyb,
                             input int np, input bit vm);
    int bad = 0;
    int nl = 0;
    logic [47:0] ed;
    logic el;
    chk({tag, "_count"}, 64'(q.size()), 64'(2 * np + 2));
    for (int j = 0; j < q.size(); j++) begin
      if (j == 0) begin
        ed = eys; el = 1'b0;
      end else if (j == 1) begin
        ed = eyb; el = 1'b0;
      end else if (j < np + 2) begin
        ed = pix(j - 2, vm); el = (j == np + 1);
      end else begin
        ed = pix(j - np - 2, vm); el = (j == 2 * np + 1);
      end
      if (q[j].d !== ed || q[j].l !== el) bad++;
      if (q[j].l === 1'b1) nl++;
    end
    chk({tag, "_bad_beats"}, 64'(bad), 64'd0);
    chk({tag, "_tlast_total"}, 64'(nl), 64'd2);
  endtask

  initial begin
    int gap;
    int stalls;
    rstn = 1'b0; start = 1'b0; gpio_N_sel = 3'd0;
    ys = '0; yb = '0;
    s_axis_tdata = '0; s_axis_tvalid = 1'b0;
    s_axis_tlast = 1'b0; m_axis_tready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_ctrl", 64'({busy, done, err_tlast,
        s_axis_tready, m_axis_tvalid, m_axis_tlast}), 64'd0);
    chk("reset_tdata", 64'(m_axis_tdata), 64'd0);
    rstn = 1'b1;
    @(posedge clk); #1;

    // basic frame, N=4
    q.delete(); done_cnt = 0;
    m_axis_tready = 1'b1;
    do_start(3'd0, YS1, 48'd0);
    chk("start_busy", 64'(busy), 64'd1);
    chk("start_tvalid", 64'(m_axis_tvalid), 64'd1);
    chk("start_tdata", 64'(m_axis_tdata), 64'(YS1));
    drive(16, -1, 1'b0, 1'b0, 1'b0, 0, 200);
    settle();
    check_frame("basic", YS1, 48'd0, 16, 1'b0);
    chk("basic_done", 64'(done_cnt), 64'd1);
    chk("basic_err", 64'(err_tlast), 64'd0);
    chk("basic_idle", 64'({busy, m_axis_tvalid}), 64'd0);

    // throttled handshakes
    q.delete(); done_cnt = 0;
    do_start(3'd0, YS1, 48'd0);
    drive(16, -1, 1'b1, 1'b0, 1'b0, 0, 400);
    settle();
    check_frame("thr", YS1, 48'd0, 16, 1'b0);
    chk("thr_done", 64'(done_cnt), 64'd1);

    // early upstream tlast on pixel 10
    q.delete(); done_cnt = 0;
    do_start(3'd0, YS1, 48'd0);
    drive(16, 9, 1'b0, 1'b0, 1'b0, 0, 200);
    settle();
    check_frame("frm", YS1, 48'd0, 16, 1'b0);
    chk("frm_err_before", 64'(q[11].e), 64'd0);
    chk("frm_err_after", 64'(q[12].e), 64'd1);
    chk("frm_err_end", 64'(err_tlast), 64'd1);

    // start pulse during SCAN is ignored
    q.delete(); done_cnt = 0;
    do_start(3'd0, 48'h0000_0003_0000, 48'h0000_0000_4000);
    drive(16, -1, 1'b0, 1'b0, 1'b1, 0, 200);
    settle();
    check_frame("poke", 48'h0000_0003_0000,
                48'h0000_0000_4000, 16, 1'b0);
    chk("poke_done", 64'(done_cnt), 64'd1);
    chk("poke_err_cleared", 64'(err_tlast), 64'd0);
    chk("poke_idle", 64'({busy, m_axis_tvalid}), 64'd0);

    // maximum size, N=128, value = index
    q.delete(); done_cnt = 0;
    do_start(3'd5, YS1, 48'h0000_0000_0001);
    drive(16384, -1, 1'b0, 1'b1, 1'b0, 0, 40000);
    settle();
    check_frame("max", YS1, 48'h1, 16384, 1'b1);
    chk("max_done", 64'(done_cnt), 64'd1);
    gap = 99;
    stalls = -1;
    if (q.size() == 32770) begin
      // REPLAY is entered at the edge ending the last scan
      // beat; valid within 2 cycles gives a gap of <= 3.
      gap = q[16386].c - q[16385].c;
      stalls = 0;
      for (int j = 16387; j < 32770; j++)
        if (q[j].c - q[j - 1].c != 1) stalls++;
    end
    chk("max_first_replay_gap", 64'(gap <= 3), 64'd1);
    chk("max_replay_stalls", 64'(stalls), 64'd0);

    // reset in the middle of REPLAY
    q.delete(); done_cnt = 0;
    do_start(3'd0, YS1, 48'd0);
    drive(16, -1, 1'b0, 1'b0, 1'b0, 20, 200);
    chk("midrst_in_replay", 64'(busy), 64'd1);
    rstn = 1'b0;
    #1;
    chk("midrst_ctrl", 64'({busy, done, err_tlast,
        s_axis_tready, m_axis_tvalid, m_axis_tlast}), 64'd0);
    chk("midrst_tdata", 64'(m_axis_tdata), 64'd0);
    @(posedge clk); #1;
    rstn = 1'b1;
    @(posedge clk); #1;
    q.delete(); done_cnt = 0;
    do_start(3'd7, 48'h0000_0002_0000, 48'h0000_0000_8000);
    drive(16384, -1, 1'b0, 1'b1, 1'b0, 0, 40000);
    settle();
    check_frame("post_rst", 48'h0000_0002_0000,
                48'h0000_0000_8000, 16384, 1'b1);
    chk("post_rst_done", 64'(done_cnt), 64'd1);

    $display("TB_RESULT checks=%0d failures=%0d",
             checks, fails);
    $finish;
  end

endmodule
